// File: rtl/sha256_pkg.sv
// Shared constants, sigma helpers and FSM state type for the SHA-256 block sequencer.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_WAIT_DONE,
        ST_OUT,
        ST_INIT
    } state_t;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Chaining-state IV the core falls back to after its reset pulse.
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_block_sequencer_if.sv
// Host-side message word stream and digest handshake of the block sequencer.
interface sha256_block_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready;

    modport master (
        output in_valid, in_data, in_last, digest_ready,
        input  in_ready, digest, digest_valid
    );

    modport slave (
        input  in_valid, in_data, in_last, digest_ready,
        output in_ready, digest, digest_valid
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// 16-word message window: serial load, then two-words-per-cycle schedule expansion.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_advance,
    input  logic        i_expand,
    input  logic [2:0]  i_idx,
    output logic [31:0] o_w0,
    output logic [31:0] o_w1
);

    logic [31:0] r_win [16];
    logic [31:0] w_new0;
    logic [31:0] w_new1;

    // Window holds W[i-16..i-1]; W[i+1] draws on W[i-1] so both words come from the current window.
    assign w_new0 = s1(r_win[14]) + r_win[9]  + s0(r_win[1]) + r_win[0];
    assign w_new1 = s1(r_win[15]) + r_win[10] + s0(r_win[2]) + r_win[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
        end else if (i_load) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= i_word;
        end else if (i_advance && i_expand) begin
            for (int i = 0; i < 14; i++) r_win[i] <= r_win[i+2];
            r_win[14] <= w_new0;
            r_win[15] <= w_new1;
        end
    end

    always_comb begin
        o_w0 = '0;
        o_w1 = '0;
        if (i_advance) begin
            if (i_expand) begin
                o_w0 = w_new0;
                o_w1 = w_new1;
            end else begin
                o_w0 = r_win[{i_idx, 1'b0}];
                o_w1 = r_win[{i_idx, 1'b1}];
            end
        end
    end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Feeds a two-rounds-per-cycle SHA-256 core: block load, schedule/K supply, digest capture, re-init.
//   state     | meaning
//   IDLE      | between messages, next cycle opens LOAD
//   LOAD      | accepting 16 message words
//   START     | one-cycle start pulse to the core
//   RUN       | 32 cycles presenting W/K pairs
//   WAIT_DONE | waiting for comp_done, bounded by DONE_TIMEOUT
//   OUT       | digest offered until accepted
//   INIT      | one-cycle core reset back to the IV
module sha256_block_sequencer
    import sha256_pkg::*;
#(
    parameter int DONE_TIMEOUT = 8,
    parameter bit CHECK_T      = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sha256_block_sequencer_if.slave   host,
    output logic                      o_core_start,
    output logic                      o_core_valid,
    output logic [31:0]               o_core_w0,
    output logic [31:0]               o_core_w1,
    output logic [31:0]               o_core_k0,
    output logic [31:0]               o_core_k1,
    input  logic [5:0]                i_core_t,
    input  logic                      i_core_done,
    input  logic [255:0]              i_core_h,
    output logic                      o_core_rst_n,
    output logic                      o_busy,
    output logic                      o_err
);

    localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DONE_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_wcnt;
    logic               r_last;
    logic [4:0]         r_j;
    logic [TMR_W-1:0]   r_tmr;
    logic [255:0]       r_h;
    logic               r_init_n;
    logic               r_err;
    logic               w_in_ready;
    logic               w_start;
    logic               w_valid;
    logic               w_dig_valid;
    logic               w_accept;
    logic               w_timeout;
    logic               w_t_err;
    logic               w_done_err;

    assign w_accept   = w_in_ready && host.in_valid;
    assign w_timeout  = (r_state == ST_WAIT_DONE) && !i_core_done && (r_tmr == '0);
    assign w_t_err    = CHECK_T && w_valid && (i_core_t != {r_j, 1'b0});
    assign w_done_err = w_valid && i_core_done;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_start     = 1'b0;
        w_valid     = 1'b0;
        w_dig_valid = 1'b0;
        case (r_state)
            ST_IDLE:      w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_in_ready = 1'b1;
                if (host.in_valid && r_wcnt == 4'd15) w_state_nxt = ST_START;
            end
            ST_START: begin
                w_start     = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_valid = 1'b1;
                if (r_j == 5'd31) w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_core_done) w_state_nxt = r_last ? ST_OUT : ST_LOAD;
                else if (w_timeout) w_state_nxt = ST_INIT;
            end
            ST_OUT: begin
                w_dig_valid = 1'b1;
                if (host.digest_ready) w_state_nxt = ST_INIT;
            end
            ST_INIT:      w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_init_n <= 1'b1;
            r_wcnt   <= '0;
            r_last   <= 1'b0;
            r_j      <= '0;
            r_tmr    <= '0;
            r_h      <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_init_n <= (w_state_nxt != ST_INIT);
            if (w_accept) begin
                r_wcnt <= r_wcnt + 4'd1;
                if (r_wcnt == 4'd15) r_last <= host.in_last;
            end
            if (w_start) r_j <= '0;
            else if (w_valid) r_j <= r_j + 5'd1;
            if (w_valid && r_j == 5'd31) r_tmr <= TMR_LOAD;
            else if (r_state == ST_WAIT_DONE && r_tmr != '0) r_tmr <= r_tmr - TMR_W'(1);
            if (r_state == ST_WAIT_DONE && i_core_done) r_h <= i_core_h;
            if (w_t_err || w_done_err || w_timeout) r_err <= 1'b1;
        end
    end

    sha256_msg_schedule u_sched (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_accept),
        .i_word    (host.in_data),
        .i_advance (w_valid),
        .i_expand  (r_j[4] | r_j[3]),
        .i_idx     (r_j[2:0]),
        .o_w0      (o_core_w0),
        .o_w1      (o_core_w1)
    );

    assign o_core_k0         = w_valid ? K_ROM[{r_j, 1'b0}] : '0;
    assign o_core_k1         = w_valid ? K_ROM[{r_j, 1'b1}] : '0;
    assign o_core_start      = w_start;
    assign o_core_valid      = w_valid;
    assign o_core_rst_n      = rst_n & r_init_n;
    assign o_busy            = (r_state != ST_IDLE);
    assign o_err             = r_err;
    assign host.in_ready     = w_in_ready;
    assign host.digest       = r_h;
    assign host.digest_valid = w_dig_valid;

endmodule

// File: doc/sha256_block_sequencer.md
Name: sha256_block_sequencer

Overview:
Controller that feeds the two-rounds-per-cycle SHA-256 compression core (`sha256_compression`). It does five things:
- Accepts 512-bit message blocks as a 32-bit word stream.
- Expands the message schedule two W words per cycle and supplies the matching K constants.
- Drives the core's start/valid_in and checks its round index t.
- Captures the digest after the last block of a message.
- Re-initialises the core's chaining state between messages.

Parameters:
DONE_TIMEOUT, 8, max cycles to wait for comp_done after the last pair before flagging an error
CHECK_T, 1, when 1, compare the core's t output against the internal pair index

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  message word valid
in_ready  out  1  sequencer can accept a word
in_data  in  32  message word, big-endian; first word = W[0]
in_last  in  1  sampled with the 16th word; marks the final block of the message
core_start  out  1  one-cycle start pulse to the core
core_valid  out  1  valid_in to the core
core_w0, core_w1  out  32 each  W[2j], W[2j+1]
core_k0, core_k1  out  32 each  K[2j], K[2j+1]
core_t  in  6  t output of the core
core_done  in  1  comp_done from the core
core_h  in  256  H_out_0..7 concatenated, H0 in the MSBs
core_rst_n  out  1  reset to the core = rst_n AND a registered init pulse
digest  out  256  captured hash
digest_valid  out  1  digest available
digest_ready  in  1  consumer accepts the digest
busy  out  1  state != IDLE
err  out  1  sticky; t mismatch or done timeout; cleared only by rst_n

Behaviour:
- Reset values: in_ready=0, core_start=0, core_valid=0, all W/K outputs 0, digest=0, digest_valid=0, busy=0, err=0; core_rst_n low while rst_n is low.
- States: IDLE, LOAD, START, RUN, WAIT_DONE, OUT, INIT.
- IDLE:
  - Go to LOAD on the next cycle.
  - in_ready=0 in IDLE.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready cycle shifts in_data into the 16-word window.
  - A 4-bit word counter counts the words; on the 16th word latch in_last into last_blk and go to START.
- START:
  - core_start=1 for exactly one cycle; in_ready=0.
  - Clear the 5-bit pair index j to 0, then go to RUN.
- RUN:
  - core_valid=1.
  - Outputs present W[2j], W[2j+1], K[2j], K[2j+1] combinationally from the window and the K ROM.
  - j increments every cycle.
  - Window update for j>=8: shift by two and append:
    - W[i] = s1(W[i-2]) + W[i-7] + s0(W[i-15]) + W[i-16], mod 2^32.
    - W[i+1] uses W[i-1], not W[i], so both new words come from the current window.
  - s0 = ROTR7^ROTR18^SHR3; s1 = ROTR17^ROTR19^SHR10.
  - If CHECK_T=1 and core_t != 2j while core_valid=1, set err.
  - After the cycle with j=31 (32 RUN cycles), go to WAIT_DONE with core_valid=0.
- WAIT_DONE:
  - On core_done=1, capture core_h into an internal H register.
    - last_blk=1: go to OUT.
    - Otherwise: go to LOAD; core chaining state is retained.
  - If DONE_TIMEOUT cycles pass without core_done, set err and go to INIT.
- OUT:
  - digest = captured H; digest_valid=1 until the cycle digest_ready=1.
  - Then drop digest_valid and go to INIT.
  - digest stays stable while valid.
- INIT:
  - Drive the registered init pulse low for exactly one cycle, so the core's H returns to the IV.
  - Then go to IDLE.
  - core_rst_n re-asserts high synchronously to clk.
- Simultaneous events:
  - core_done arriving during RUN is ignored and sets err.
  - in_valid outside LOAD is ignored (in_ready=0).
- Reset mid-operation: every state returns to IDLE, the window is cleared, and core_rst_n is low for the whole reset.

Decomposition:
- Package sha256_pkg holds:
  - the 64-entry K ROM constant;
  - the IV0..IV7 constants;
  - s0/s1 functions;
  - the state enum.
- Sub-module sha256_msg_schedule holds the 16x32 window, the shift/append logic and the two-word output mux. Its inputs are load, word, advance and expand.

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018, in_last=1) -> START pulse one cycle after the 16th word; RUN pair 0 gives w0=0x61626380, w1=0, k0=0x428a2f98, k1=0x71374491.
- Same block, pair j=8 -> w0=0x61626380, w1=0x000F0000, k0=0xe49b69c1, k1=0xefbe4786.
- Two-block message (first in_last=0) -> no digest_valid and no init pulse after block 1; LOAD re-entered with in_ready=1; digest only after block 2.
- Core model holds core_done low -> err=1 after DONE_TIMEOUT (8) cycles; core_rst_n pulses low for one cycle; busy=0 after.
- digest_ready held low for 5 cycles in OUT -> digest_valid stays high and digest unchanged; INIT occurs on the cycle after ready.
- rst_n asserted during RUN at j=10 -> all outputs reach reset values immediately; the next block restarts cleanly at pair 0 with err=0.
